// File: rtl/serial_adder_unit.sv
// serial_adder_unit: bit-serial add/subtract unit. One full-adder slice is
// used LSB first for WIDTH cycles, with the carry held in a flop between
// slices. The unit accepts operands on a start/done handshake.
//
// Optional feature macro: SERIAL_ADDER_ZERO_FLAG_EN (adds the zero flag output)
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request; accepted in IDLE or DONE
//   op     - 0 = a+b, 1 = a-b
//   a, b   - operands, captured on an accepted start
//   busy   - operation in progress
//   done   - one-cycle pulse when z/cout/ovf are valid
//   z      - result; holds until the next accepted start
//   cout   - carry out of the MSB slice (subtract: 1 = no borrow)
//   ovf    - signed overflow (carry into MSB xor carry out of MSB)
//   zero   - z == 0 (only with SERIAL_ADDER_ZERO_FLAG_EN)
module serial_adder_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             load_c;
    logic             step_c;
    logic             last_c;
    logic             sum_c;
    logic             carry_c;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [CW-1:0]    count;
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    logic             any_one;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state and datapath control; start in DONE is taken like IDLE
    always_comb begin
        state_nxt = state;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        load_c    = 1'b0;
        step_c    = 1'b0;
        last_c    = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = RUN;
                    busy_nxt  = 1'b1;
                end
            end
            RUN: begin
                step_c   = 1'b1;
                busy_nxt = 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    last_c    = 1'b1;
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Single full-adder slice on the LSBs
    always_comb begin
        sum_c   = opa[0] ^ opb[0] ^ carry;
        carry_c = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
    end

    // Operand shifters, carry flop, result shifter and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            count <= '0;
            z     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
            any_one <= 1'b0;
            zero    <= 1'b0;
`endif
        end else if (load_c) begin
            // Subtract as a + ~b + 1: the +1 enters as the initial carry
            opa   <= a;
            opb   <= op ? ~b : b;
            carry <= op;
            count <= '0;
            z     <= '0;
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
            any_one <= 1'b0;
            zero    <= 1'b0;
`endif
        end else if (step_c) begin
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            z     <= {sum_c, z[WIDTH-1:1]};
            carry <= carry_c;
            count <= count + CW'(1);
            if (last_c) begin
                // carry still holds the carry into the MSB slice here
                cout <= carry_c;
                ovf  <= carry ^ carry_c;
            end
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
            any_one <= any_one | sum_c;
            if (last_c) begin
                zero <= ~(any_one | sum_c);
            end
`endif
        end
    end

endmodule

// File: tb/tb_serial_adder_unit.sv
// Scoreboard bench for serial_adder_unit at WIDTH=32 and WIDTH=4.
module tb_serial_adder_unit;

    typedef struct packed {
        logic [63:0] z;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 32-bit instance
    logic        rst32_n, start32, opi32;
    logic [31:0] a32, b32, z32;
    logic        busy32, done32, cout32, ovf32, zero32;
    exp_t        q32[$];
    exp_t        e32;

    // 4-bit instance
    logic        rst4_n, start4, opi4;
    logic [3:0]  a4, b4, z4;
    logic        busy4, done4, cout4, ovf4, zero4;
    exp_t        q4[$];
    exp_t        e4;

    serial_adder_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst32_n), .start(start32), .op(opi32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .z(z32),
        .cout(cout32), .ovf(ovf32)
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
        , .zero(zero32)
`endif
    );

    serial_adder_unit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .start(start4), .op(opi4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .z(z4),
        .cout(cout4), .ovf(ovf4)
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
        , .zero(zero4)
`endif
    );

`ifndef SERIAL_ADDER_ZERO_FLAG_EN
    assign zero32 = 1'b0;
    assign zero4  = 1'b0;
`endif

    // Reference: modular arithmetic plus signed-range overflow rule
    function automatic exp_t model(input int unsigned w, input logic [63:0] a,
                                   input logic [63:0] b, input logic op);
        exp_t        r;
        logic [64:0] mask;
        logic [64:0] aa;
        logic [64:0] bb;
        logic [64:0] full;
        logic        sa, sb, sz;
        mask = (65'd1 << w) - 65'd1;
        aa   = {1'b0, a} & mask;
        bb   = {1'b0, b} & mask;
        if (!op) begin
            full   = aa + bb;
            r.z    = 64'(full & mask);
            r.cout = full[w];
        end else begin
            full   = aa - bb;
            r.z    = 64'(full & mask);
            r.cout = (aa >= bb);
        end
        sa = aa[w-1];
        sb = bb[w-1];
        sz = r.z[w-1];
        r.ovf  = op ? ((sa != sb) && (sz != sa)) : ((sa == sb) && (sz != sa));
        r.zero = (r.z == 64'd0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop the oldest expectation on every done pulse
    always @(negedge clk) begin
        if (done32) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done32: got done=1 expected no pending op");
            end else begin
                e32 = q32.pop_front();
                chk("z32", 64'(z32), e32.z);
                chk("cout32", 64'(cout32), 64'(e32.cout));
                chk("ovf32", 64'(ovf32), 64'(e32.ovf));
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
                chk("zero32", 64'(zero32), 64'(e32.zero));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done4: got done=1 expected no pending op");
            end else begin
                e4 = q4.pop_front();
                chk("z4", 64'(z4), e4.z);
                chk("cout4", 64'(cout4), 64'(e4.cout));
                chk("ovf4", 64'(ovf4), 64'(e4.ovf));
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
                chk("zero4", 64'(zero4), 64'(e4.zero));
`endif
            end
        end
    end

    // Issue one op at the current negedge; scramble inputs after the start
    // edge; optionally pulse an ignored start at cycle glitch_at. Returns at
    // the negedge where done is high (the DONE cycle).
    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic o,
                         input int glitch_at);
        int n;
        start32 = 1'b1; a32 = a; b32 = b; opi32 = o;
        q32.push_back(model(32, 64'(a), 64'(b), o));
        @(negedge clk);
        start32 = 1'b0; a32 = $urandom; b32 = $urandom; opi32 = 1'($urandom);
        chk("busy32_after_start", 64'(busy32), 64'd1);
        n = 0;
        while (!done32 && n < 200) begin
            @(negedge clk);
            n++;
            start32 = (n == glitch_at);
            if (n == glitch_at) begin
                a32 = 32'd1; b32 = 32'd1; opi32 = 1'b0;
            end
        end
        start32 = 1'b0;
        chk("latency32", 64'(n), 64'd32);
        chk("busy32_in_done", 64'(busy32), 64'd0);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic o);
        int n;
        start4 = 1'b1; a4 = a; b4 = b; opi4 = o;
        q4.push_back(model(4, 64'(a), 64'(b), o));
        @(negedge clk);
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); opi4 = 1'($urandom);
        n = 0;
        while (!done4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("latency4", 64'(n), 64'd4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst32_n = 1'b0; start32 = 1'b0; opi32 = 1'b0; a32 = '0; b32 = '0;
        rst4_n  = 1'b0; start4  = 1'b0; opi4  = 1'b0; a4  = '0; b4  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy32), 64'd0);
        chk("rst_done", 64'(done32), 64'd0);
        chk("rst_z", 64'(z32), 64'd0);
        chk("rst_flags", 64'({cout32, ovf32, zero32}), 64'd0);
        rst32_n = 1'b1;
        rst4_n  = 1'b1;
        @(negedge clk);

        // Directed 32-bit cases; back-to-back calls start during DONE
        run32(32'd5, 32'd3, 1'b0, 0);
        @(negedge clk);
        run32(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        run32(32'h7FFF_FFFF, 32'd1, 1'b0, 0);
        @(negedge clk);
        run32(32'd3, 32'd5, 1'b1, 0);
        run32(32'h8000_0000, 32'd1, 1'b1, 0);
        @(negedge clk);
        run32(32'd10, 32'd20, 1'b0, 5);
        @(negedge clk);

        // Asynchronous reset in the middle of a run (previous op left cout=1)
        run32(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        @(negedge clk);
        start32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; opi32 = 1'b0;
        @(negedge clk);
        start32 = 1'b0;
        repeat (11) @(negedge clk);
        chk("busy_before_reset", 64'(busy32), 64'd1);
        rst32_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy32), 64'd0);
        chk("arst_done", 64'(done32), 64'd0);
        chk("arst_z", 64'(z32), 64'd0);
        chk("arst_cout", 64'(cout32), 64'd0);
        chk("arst_ovf", 64'(ovf32), 64'd0);
        @(negedge clk);
        rst32_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) seen++;
        end
        chk("no_done_after_reset", 64'(seen), 64'd0);

        // Random 32-bit ops with random idle gaps
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(1, 0) != 0) @(negedge clk);
            run32($urandom, $urandom, 1'($urandom), 0);
        end
        @(negedge clk);

        // Exhaustive WIDTH=4
        for (int o = 0; o < 2; o++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    if ($urandom_range(3, 0) == 0) @(negedge clk);
                    run4(4'(x), 4'(y), 1'(o));
                end
            end
        end
        repeat (3) @(negedge clk);

        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q4_drained", 64'(q4.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
